// File: rtl/spike_feature_serializer_if.sv
// spike_feature_serializer_if: event-in and feature-word-out handshakes of the serializer
`timescale 1ns/1ps
interface spike_feature_serializer_if #(
  parameter int FEATURES = 3,
  parameter int IN_WIDTH = 10,
  parameter int CHANNEL_COUNT = 1
);
  localparam int CW = CHANNEL_COUNT > 1 ? $clog2(CHANNEL_COUNT) : 1;
  logic ev_valid;
  logic ev_ready;
  logic [FEATURES*IN_WIDTH-1:0] ev_features;
  logic [CW-1:0] ev_channel;
  logic ready;
  logic valid;
  logic [IN_WIDTH-1:0] sample;
  logic [CW-1:0] channel;
  logic first;
  logic last;
  modport master (
    output ev_valid, ev_features, ev_channel, ready,
    input ev_ready, valid, sample, channel, first, last
  );
  modport slave (
    input ev_valid, ev_features, ev_channel, ready,
    output ev_ready, valid, sample, channel, first, last
  );
endinterface

// File: rtl/spike_feature_serializer.sv
// spike_feature_serializer: buffers spike events and streams their features one word per transfer
`timescale 1ns/1ps
module spike_feature_serializer #(
  parameter int FEATURES = 3,
  parameter int IN_WIDTH = 10,
  parameter int CHANNEL_COUNT = 1,
  parameter int DEPTH = 4,
  parameter int DROP_WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  spike_feature_serializer_if.slave bus,
  output logic [$clog2(DEPTH):0] fill,
  output logic [DROP_WIDTH-1:0] drop_count
);
  localparam int CW = CHANNEL_COUNT > 1 ? $clog2(CHANNEL_COUNT) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam int IW = FEATURES > 1 ? $clog2(FEATURES) : 1;
  localparam int FW = FEATURES * IN_WIDTH;
  logic [CW+FW-1:0] mem [DEPTH];
  logic [CW+FW-1:0] head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [IW-1:0] idx;
  logic push, xfer, pop;
  assign head = mem[rd_ptr];
  assign bus.ev_ready = fill != (AW+1)'(DEPTH);
  assign bus.valid = fill != '0;
  assign bus.sample = head[idx*IN_WIDTH +: IN_WIDTH];
  assign bus.channel = head[FW +: CW];
  assign bus.first = idx == '0;
  assign bus.last = idx == IW'(FEATURES-1);
  assign push = bus.ev_valid && bus.ev_ready;
  assign xfer = bus.valid && bus.ready;
  assign pop = xfer && bus.last;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {bus.ev_channel, bus.ev_features};
  // a final pop and a push in the same cycle leave occupancy unchanged
  always_ff @(posedge clk)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      idx <= '0;
      fill <= '0;
      drop_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (xfer) idx <= bus.last ? '0 : idx + 1'b1;
      fill <= push && !pop ? fill + 1'b1 : pop && !push ? fill - 1'b1 : fill;
      if (bus.ev_valid && !bus.ev_ready && drop_count != '1) drop_count <= drop_count + 1'b1;
    end
endmodule

// File: doc/spike_feature_serializer.md
Name: spike_feature_serializer

Overview:
- Upstream neighbour of the decision-tree classifier.
- Accepts one spike event per cycle from the feature-extraction stage; each event carries FEATURES parallel feature words plus a channel tag.
- Buffers events in a small FIFO and streams each event's features one word per transfer into the classifier's sample/in_valid/ready interface.
- Counts events that arrive while the buffer is full; those events are dropped.

Parameters:
FEATURES, 3, feature words per event.
IN_WIDTH, 10, width of one signed feature word.
CHANNEL_COUNT, 1, number of recording channels; tag width CW = max(1, $clog2(CHANNEL_COUNT)).
DEPTH, 4, event FIFO depth; power of 2, >= 2.
DROP_WIDTH, 8, width of the dropped-event counter.

Ports:
clk  input  1  clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
ev_valid  input  1  event present on ev_features/ev_channel this cycle.
ev_ready  output  1  FIFO not full; an event is accepted when ev_valid && ev_ready.
ev_features  input  FEATURES*IN_WIDTH  packed features; feature k at bits [k*IN_WIDTH +: IN_WIDTH].
ev_channel  input  CW  channel tag of the event.
ready  input  1  classifier can take a feature word this cycle.
valid  output  1  feature word present on sample; drives classifier in_valid.
sample  output  IN_WIDTH  current feature word.
channel  output  CW  channel tag of the event being streamed.
first  output  1  sample is feature 0 of its event.
last  output  1  sample is feature FEATURES-1 of its event.
fill  output  $clog2(DEPTH)+1  number of events held, including a partially streamed event.
drop_count  output  DROP_WIDTH  events lost to a full FIFO; saturating.

Behaviour:
- Reset (synchronous, active-high): FIFO empty, read/write pointers 0, feature index 0, drop_count 0. Outputs during and after reset: ev_ready=1, valid=0, fill=0, first=1, last=(FEATURES==1), sample/channel = stored head contents (don't-care).
- Reset mid-stream discards all buffered events, including a partially streamed one; nothing is resumed.
- Storage: DEPTH entries of {ev_channel, ev_features}. Pointers wrap modulo DEPTH. An occupancy counter distinguishes full from empty.
- ev_ready = (fill != DEPTH). It is combinational from registered state only, with no path from ev_valid or ready.
- Push: on ev_valid && ev_ready, write the entry and increment the write pointer.
- Drop: on ev_valid && !ev_ready, leave the FIFO unchanged and increment drop_count. drop_count saturates at all-ones and never wraps.
- Output side: valid = (fill != 0). sample = head feature[idx]; channel = head tag; first = (idx==0); last = (idx==FEATURES-1). All are combinational from registers.
- Transfer: occurs on valid && ready.
  - If !last: idx <= idx+1.
  - If last: idx <= 0, the head is popped, and the read pointer advances.
- Stalls: if ready is low, every output holds. Features of one event are never reordered or skipped, and the next event never interleaves with the current one.
- Latency: an event pushed at edge t has valid=1 in the cycle after t when the FIFO was empty (one-cycle fall-through via registers). An event takes exactly FEATURES transfers.
- Simultaneous push and final pop in one cycle: fill is unchanged. Both pointers advance and both operations are honoured.
- Simultaneous push and non-final transfer: fill increments.
- When full, a final pop in the same cycle as ev_valid does not admit the event, because ev_ready was already 0. That event is counted as dropped.
- fill: +1 on push only, -1 on final pop only, unchanged when both occur or neither occurs.
- idx width: max(1, $clog2(FEATURES)).

Test Plan:
- Single event: defaults, ready=1, push features {0x005, 0x3FF, 0x200}, channel 0 → valid rises next cycle; sample = 0x005 (first=1), then 0x3FF, then 0x200 (last=1) on 3 consecutive cycles; then valid=0, fill=0.
- Backpressure: same event, ready=0 for 2 cycles after the first transfer → sample holds 0x3FF with valid=1 throughout; 0x200 follows once ready=1; exactly 3 transfers total.
- Fill/drop: ready=0, push 6 back-to-back events → ev_ready=0 after the 4th; fill=4; drop_count=2. Then ready=1 → events 1-4 emerge in push order, 12 transfers total.
- Simultaneous push/pop: DEPTH=4, fill=1, ev_valid asserted in the cycle of that event's last transfer → fill stays 1; the new event's first word appears on the next cycle.
- Saturation: DROP_WIDTH=2, FIFO full, ev_valid held high for 5 cycles → drop_count reads 1, 2, 3, 3, 3.
- Mid-stream reset: reset=1 for one cycle while idx=1 with 2 events buffered → next cycle valid=0, fill=0, drop_count=0, ev_ready=1; a new push streams from feature 0.
